// File: rtl/waw_tracker_pkg.sv
// Shared entry layout and helpers for the in-flight destination scoreboard.
package waw_tracker_pkg;

    localparam int ENT_ADDR_W = 5;
    localparam int ENT_LAT_W  = 4;
    localparam int NUM_SRC    = 3;

    typedef struct packed {
        logic                  valid;
        logic                  tracked;
        logic                  killed;
        logic [ENT_ADDR_W-1:0] rd;
        logic                  fp;
        logic [ENT_LAT_W-1:0]  cnt;
    } entry_t;

    function automatic int ent_idx(input int unit, input int slot, input int depth);
        return unit * depth + slot;
    endfunction

    // Killed entries no longer own their destination, so they never hazard.
    function automatic logic ent_match(input entry_t e, input logic [ENT_ADDR_W-1:0] rd,
                                       input logic fp);
        return e.valid && e.tracked && !e.killed && (e.rd == rd) && (e.fp == fp);
    endfunction

endpackage

// File: rtl/waw_slot.sv
// One scoreboard entry: load, countdown to writeback, WAW kill and hazard matching.
module waw_slot
    import waw_tracker_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                flush_i,
    input  logic                                load_i,
    input  entry_t                              load_ent_i,
    input  logic                                kill_i,
    input  logic [NUM_SRC-1:0][ENT_ADDR_W-1:0]  src_rd_i,
    input  logic [NUM_SRC-1:0]                  src_vld_i,
    input  logic [NUM_SRC-1:0]                  src_fp_i,
    input  logic [ENT_ADDR_W-1:0]               wr_rd_i,
    input  logic                                wr_fp_i,
    output logic [NUM_SRC-1:0]                  src_hit_o,
    output logic                                wr_hit_o,
    output logic                                retire_o,
    output logic                                kill_o,
    output logic                                busy_o,
    output logic                                free_o
);

    entry_t ent_q, ent_d;

    assign retire_o = ent_q.valid && (ent_q.cnt == ENT_LAT_W'(1));
    assign kill_o   = retire_o && ent_q.killed;
    assign busy_o   = ent_q.valid && !retire_o;
    assign free_o   = !busy_o;
    assign wr_hit_o = ent_match(ent_q, wr_rd_i, wr_fp_i);

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        assign src_hit_o[j] = src_vld_i[j] && ent_match(ent_q, src_rd_i[j], src_fp_i[j]);
    end

    // A retiring entry is dropped rather than killed; a same-cycle load replaces it.
    always_comb begin
        ent_d = ent_q;
        if (flush_i) begin
            ent_d.valid = 1'b0;
        end else if (load_i) begin
            ent_d = load_ent_i;
        end else if (retire_o) begin
            ent_d.valid = 1'b0;
        end else if (ent_q.valid) begin
            if (ent_q.cnt > ENT_LAT_W'(1)) ent_d.cnt = ent_q.cnt - 1'b1;
            if (kill_i) ent_d.killed = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ent_q <= '0;
        else          ent_q <= ent_d;
    end

endmodule

// File: rtl/waw_rd_tracker.sv
// Per-unit in-flight destination scoreboard: issue grant, RAW stall, WAW writeback kill.
module waw_rd_tracker
    import waw_tracker_pkg::*;
#(
    parameter int NUM_UNITS = 9,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = ENT_ADDR_W,
    parameter int LAT_W     = ENT_LAT_W
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              flush_i,
    input  logic                                              issue_valid_i,
    input  logic [((NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1)-1:0] issue_unit_i,
    input  logic [ADDR_W-1:0]                                 issue_rd_i,
    input  logic                                              issue_wr_i,
    input  logic                                              issue_rd_fp_i,
    input  logic [LAT_W-1:0]                                  issue_lat_i,
    input  logic [NUM_SRC*ADDR_W-1:0]                         issue_rs_i,
    input  logic [NUM_SRC-1:0]                                issue_rs_vld_i,
    input  logic [NUM_SRC-1:0]                                issue_rs_fp_i,
    output logic                                              issue_ready_o,
    output logic                                              raw_stall_o,
    output logic [NUM_UNITS-1:0]                              unit_full_o,
    output logic [NUM_UNITS*DEPTH-1:0]                        retire_o,
    output logic [NUM_UNITS*DEPTH-1:0]                        kill_o
);

    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_SRC-1:0][ADDR_W-1:0]                rs;
    logic [NUM_UNITS-1:0][DEPTH-1:0]               busy, free, alloc, wr_hit;
    logic [NUM_UNITS-1:0][DEPTH-1:0][NUM_SRC-1:0]  src_hit;
    logic                                          iss_tracked, unit_ok, sel_full;
    entry_t                                        new_ent;

    assign rs          = issue_rs_i;
    assign iss_tracked = issue_wr_i && (issue_rd_fp_i || (issue_rd_i != '0));
    assign unit_ok     = 32'(issue_unit_i) < NUM_UNITS;
    assign sel_full    = unit_ok ? unit_full_o[issue_unit_i] : 1'b1;

    assign raw_stall_o   = issue_valid_i && (|src_hit);
    assign issue_ready_o = issue_valid_i && !raw_stall_o && !sel_full && !flush_i;

    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.tracked = iss_tracked;
        new_ent.rd      = issue_rd_i;
        new_ent.fp      = issue_rd_fp_i;
        new_ent.cnt     = (issue_lat_i == '0) ? LAT_W'(1) : issue_lat_i;
    end

    // Lowest-index free slot per unit; retiring slots count as free.
    always_comb begin
        logic seen;
        alloc = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            seen = 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                alloc[u][s] = free[u][s] && !seen;
                seen        = seen | free[u][s];
            end
        end
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        assign unit_full_o[u] = &busy[u];
        for (genvar s = 0; s < DEPTH; s++) begin : g_slot
            logic load, kill_req;
            assign load     = issue_ready_o && (issue_unit_i == UNIT_W'(u)) && alloc[u][s];
            assign kill_req = issue_ready_o && iss_tracked && wr_hit[u][s];

            waw_slot u_slot (
                .clk        (clk),
                .reset_n    (reset_n),
                .flush_i    (flush_i),
                .load_i     (load),
                .load_ent_i (new_ent),
                .kill_i     (kill_req),
                .src_rd_i   (rs),
                .src_vld_i  (issue_rs_vld_i),
                .src_fp_i   (issue_rs_fp_i),
                .wr_rd_i    (issue_rd_i),
                .wr_fp_i    (issue_rd_fp_i),
                .src_hit_o  (src_hit[u][s]),
                .wr_hit_o   (wr_hit[u][s]),
                .retire_o   (retire_o[ent_idx(u, s, DEPTH)]),
                .kill_o     (kill_o[ent_idx(u, s, DEPTH)]),
                .busy_o     (busy[u][s]),
                .free_o     (free[u][s])
            );
        end
    end

endmodule

// File: doc/waw_rd_tracker.md
# waw_rd_tracker

Parametrised scoreboard that tracks in-flight destination registers for every execution unit (integer and FP) between issue and MEM-stage writeback. It grants or stalls issue, detects RAW hazards against in-flight results, and kills the writeback of older in-flight results overwritten by a newer instruction (WAW). It sits between decode/issue and the execution units and generalises single-entry-per-unit clear decoding to multi-entry pipelined units with per-instruction latency.

## Interface
- NUM_UNITS, 9: execution units tracked.
- DEPTH, 4: in-flight entries per unit.
- ADDR_W, 5: register address width.
- LAT_W, 4: latency counter width.
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- flush_i  in  1  invalidate all entries
- issue_valid_i  in  1  instruction presented for issue
- issue_unit_i  in  $clog2(NUM_UNITS)  target unit
- issue_rd_i  in  ADDR_W  destination
- issue_wr_i  in  1  instruction writes a register
- issue_rd_fp_i  in  1  destination is FP
- issue_lat_i  in  LAT_W  cycles until writeback (0 treated as 1)
- issue_rs_i  in  3×ADDR_W  rs1, rs2, rs3
- issue_rs_vld_i  in  3  source used (rs3 only for R4)
- issue_rs_fp_i  in  3  source is FP
- issue_ready_o  out  1  issue accepted this cycle
- raw_stall_o  out  1  RAW hazard blocks issue
- unit_full_o  out  NUM_UNITS  no free slot in unit
- retire_o  out  NUM_UNITS×DEPTH  entry reaches writeback this cycle
- kill_o  out  NUM_UNITS×DEPTH  retiring entry's writeback must be suppressed

## Operation
- Entry state: valid, tracked, killed, rd, fp, cnt.
- tracked = issue_wr_i && (issue_rd_fp_i || issue_rd_i != 0); untracked entries occupy a slot only.
- Match(entry, reg, fp): valid && tracked && !killed && rd == reg && fp matches.
- raw_stall_o = issue_valid_i && any valid source matches any entry.
- unit_full_o[u] = every slot of u valid with cnt != 1.
- issue_ready_o = issue_valid_i && !raw_stall_o && !unit_full_o[issue_unit_i] && !flush_i.
- Accepted issue: allocate lowest-index free slot (invalid or retiring this cycle) of issue_unit_i; cnt = max(issue_lat_i,1).
- WAW: on accepted tracked issue, every matching entry in any unit sets killed. Instruction reading its own rd stalls on RAW instead, never kills.
- Each cycle every valid entry with cnt > 1 decrements. retire_o[e] = valid && cnt == 1; kill_o[e] = retire_o[e] && killed; entry invalidated at that edge.
- flush_i: all entries invalid at next edge; retire_o/kill_o still reflect current state that cycle.

## Timing
- Reset: all entries invalid; retire_o, kill_o, unit_full_o, raw_stall_o = 0; issue_ready_o = issue_valid_i.
- issue_ready_o, raw_stall_o, unit_full_o, retire_o, kill_o combinational from state and inputs; state updates on rising clk.
- Entry issued at edge T with latency L: retire_o high during cycle T+L-1..T+L window (exactly one cycle, the L-th after issue).
- Kill takes effect the cycle after the killing issue; entry retiring in the same cycle as the killing issue is NOT killed (write harmless, overwritten later).
- Slot retiring this cycle is reusable by a same-cycle issue; new entry wins.
- RAW against an entry with cnt == 1 still stalls (conservative, no bypass assumed).
- reset_n asserted mid-operation: all state cleared immediately, no retire/kill pulses.

## Structure
- Package waw_tracker_pkg: entry_t struct (valid, tracked, killed, rd, fp, cnt), NUM_SRC = 3, entry index helper function.
- Sub-module waw_slot: one entry register with load, decrement, kill, flush, and match outputs; instantiated NUM_UNITS×DEPTH times. Top holds allocation priority encoders and hazard reduction.

## Test plan
- Issue int x3 unit0 lat 4, then int x3 unit1 lat 1 next cycle -> unit0 entry killed; retire_o[0] and kill_o[0] high 4 cycles after first issue; unit1 retires unkilled.
- Issue FP f3 lat 3, then add x4 reading int x3 -> no RAW stall (type mismatch); then read f3 -> raw_stall_o = 1 until f3 retires.
- Issue x3, then x3 ← x3 op x1 -> raw_stall_o = 1, no kill; accepted after retire.
- Fill unit2 with 4 lat-8 entries -> unit_full_o[2] = 1, issue to unit2 stalls; issue to unit3 accepted; unit2 slot reused on the retire cycle.
- Issue x0 writes and non-writing instructions -> never stall or kill, slots still occupied.
- Flush with 5 entries in flight and issue_valid_i high -> issue_ready_o = 0, all entries gone next cycle; reset_n low mid-flight -> outputs zero immediately.
